// File: rtl/bip_uart_interface.sv
// bip_uart_interface
// Reports the result of a BIP program over a UART line. When bip_done rises,
// the 16-bit accumulator and the 8-bit instruction count are captured. They
// are then sent as three back-to-back 8N1 frames in this order:
// accumulator[15:8], accumulator[7:0], inst_count.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   accumulator  BIP accumulator, sampled on a bip_done rising edge
//   inst_count   BIP executed-instruction count, sampled with accumulator
//   bip_done     BIP completion level (stays high after halt)
//   o_tx         registered UART TX line, idle high
//
// State table:
//   state      | meaning
//   S_IDLE     | line idle, waiting for a bip_done rising edge
//   S_START    | start bit (0) of byte byte_q
//   S_DATA     | data bit bit_q of byte byte_q, LSB first
//   S_STOP     | stop bit (1) of byte byte_q
//   S_WAIT_LOW | report sent, bip_done still high; wait for it to drop
module bip_uart_interface #(
   parameter int CLKS_PER_BIT = 5208
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] accumulator,
   input  logic [7:0]  inst_count,
   input  logic        bip_done,
   output logic        o_tx
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_WAIT_LOW
   } state_t;

   localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

   state_t      state_q, state_d;
   logic        done_q;
   logic [15:0] acc_q, acc_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [15:0] baud_q, baud_d;
   logic [2:0]  bit_q, bit_d;
   logic [1:0]  byte_q, byte_d;
   logic        tx_q, tx_d;

   logic        done_edge;
   logic        baud_last;
   logic [7:0]  cur_byte;

   assign done_edge = bip_done & ~done_q;
   assign baud_last = (baud_q == BAUD_LAST);
   assign o_tx      = tx_q;

   always_comb begin
      cur_byte = cnt_q;
      case (byte_q)
         2'd0:    cur_byte = acc_q[15:8];
         2'd1:    cur_byte = acc_q[7:0];
         default: cur_byte = cnt_q;
      endcase
   end

   // tx_d is the line level for the current state; it is registered, so the
   // line trails the state by exactly one cycle for every bit alike.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      byte_d  = byte_q;
      tx_d    = 1'b1;

      case (state_q)
         S_IDLE: begin
            baud_d = '0;
            bit_d  = '0;
            byte_d = '0;
            if (done_edge) begin
               acc_d   = accumulator;
               cnt_d   = inst_count;
               state_d = S_START;
            end
         end
         S_START: begin
            tx_d   = 1'b0;
            baud_d = baud_last ? '0 : baud_q + 16'd1;
            if (baud_last) state_d = S_DATA;
         end
         S_DATA: begin
            tx_d   = cur_byte[bit_q];
            baud_d = baud_last ? '0 : baud_q + 16'd1;
            if (baud_last) begin
               if (bit_q == 3'd7) begin
                  bit_d   = '0;
                  state_d = S_STOP;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end
         end
         S_STOP: begin
            tx_d   = 1'b1;
            baud_d = baud_last ? '0 : baud_q + 16'd1;
            if (baud_last) begin
               if (byte_q < 2'd2) begin
                  byte_d  = byte_q + 2'd1;
                  state_d = S_START;
               end else begin
                  byte_d  = '0;
                  // Only re-arm once bip_done has been seen low, so a held
                  // level never produces a second report.
                  state_d = bip_done ? S_WAIT_LOW : S_IDLE;
               end
            end
         end
         S_WAIT_LOW: begin
            if (!bip_done) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         done_q  <= 1'b0;
         acc_q   <= '0;
         cnt_q   <= '0;
         baud_q  <= '0;
         bit_q   <= '0;
         byte_q  <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         done_q  <= bip_done;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         byte_q  <= byte_d;
         tx_q    <= tx_d;
      end
   end

endmodule

// File: tb/tb_bip_uart_interface.sv
// tb_bip_uart_interface
// Directed bench for bip_uart_interface with CLKS_PER_BIT=4. Inputs change on
// the falling edge and the line is sampled on the falling edge. A report
// spans 120 cycles and is compared sample-by-sample against a waveform built
// from the expected bytes.
module tb_bip_uart_interface;

   localparam int CPB   = 4;
   localparam int FRAME = 30 * CPB;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] accumulator = 16'h0000;
   logic [7:0]  inst_count = 8'h00;
   logic        bip_done = 1'b0;
   logic        o_tx;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   bip_uart_interface #(.CLKS_PER_BIT(CPB)) dut (
      .clk         (clk),
      .rst         (rst),
      .accumulator (accumulator),
      .inst_count  (inst_count),
      .bip_done    (bip_done),
      .o_tx        (o_tx)
   );

   task automatic trigger();
      @(negedge clk);
      bip_done = 1'b1;
   endtask

   task automatic drop_done();
      @(negedge clk);
      bip_done = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   // Called with the next rising edge being the done edge.
   // mut_kind: 0 none, 1 change inputs at mut_at, 2 bip_done low at mut_at
   // and high again 3 cycles later, 3 assert reset at mut_at and return.
   task automatic run_report(input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input string name,
                             input int mut_kind, input int mut_at);
      logic       s     [FRAME];
      logic       exp_w [FRAME];
      logic [7:0] eb    [3];
      logic [7:0] got;
      logic       pre;
      logic       val;
      int         werr;
      eb[0] = e0;
      eb[1] = e1;
      eb[2] = e2;
      for (int b = 0; b < 3; b++)
         for (int k = 0; k < 10; k++) begin
            if (k == 0)      val = 1'b0;
            else if (k == 9) val = 1'b1;
            else             val = eb[b][k-1];
            for (int c = 0; c < CPB; c++) exp_w[b*10*CPB + k*CPB + c] = val;
         end

      @(negedge clk);
      pre = o_tx;
      for (int i = 0; i < FRAME; i++) begin
         @(negedge clk);
         s[i] = o_tx;
         if (mut_kind == 1 && i == mut_at) begin
            accumulator = 16'h1234;
            inst_count  = 8'h99;
         end
         if (mut_kind == 2 && i == mut_at)     bip_done = 1'b0;
         if (mut_kind == 2 && i == mut_at + 3) bip_done = 1'b1;
         if (mut_kind == 3 && i == mut_at) begin
            rst = 1'b0;
            #1;
            tests_run++;
            if (o_tx !== 1'b1) begin
               tests_failed++;
               $display("FAIL %s abort: o_tx=%b required 1", name, o_tx);
            end
            return;
         end
      end

      tests_run++;
      if (pre !== 1'b1 || s[0] !== 1'b0) begin
         tests_failed++;
         $display("FAIL %s latency: tx at done edge=%b (req 1), one cycle later=%b (req 0)",
                  name, pre, s[0]);
      end
      for (int b = 0; b < 3; b++) begin
         for (int k = 0; k < 8; k++) got[k] = s[b*10*CPB + (k+1)*CPB + CPB/2];
         tests_run++;
         if (got !== eb[b]) begin
            tests_failed++;
            $display("FAIL %s byte%0d: got %02h required %02h", name, b, got, eb[b]);
         end
      end
      werr = 0;
      for (int i = 0; i < FRAME; i++) if (s[i] !== exp_w[i]) werr++;
      tests_run++;
      if (werr != 0) begin
         tests_failed++;
         $display("FAIL %s waveform: %0d of %0d samples wrong, required 0", name, werr, FRAME);
      end
      @(negedge clk);
      tests_run++;
      if (o_tx !== 1'b1) begin
         tests_failed++;
         $display("FAIL %s idle_after: o_tx=%b required 1", name, o_tx);
      end
   endtask

   task automatic check_quiet(input int cycles, input string name);
      int err;
      err = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (o_tx !== 1'b1) err++;
      end
      tests_run++;
      if (err != 0) begin
         tests_failed++;
         $display("FAIL %s: o_tx low in %0d of %0d cycles, required 0", name, err, cycles);
      end
   endtask

   task automatic test_reset();
      int err;
      err = 0;
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         bip_done = ~bip_done;
         #1;
         if (o_tx !== 1'b1) err++;
      end
      tests_run++;
      if (err != 0) begin
         tests_failed++;
         $display("FAIL reset_hold: o_tx low in %0d cycles, required 0", err);
      end
      @(negedge clk);
      bip_done = 1'b0;
      rst      = 1'b1;
      check_quiet(20, "reset_release_quiet");
   endtask

   task automatic test_basic();
      accumulator = 16'hA55A;
      inst_count  = 8'h07;
      trigger();
      run_report(8'hA5, 8'h5A, 8'h07, "basic", 0, -1);
      drop_done();
   endtask

   task automatic test_snapshot();
      accumulator = 16'hA55A;
      inst_count  = 8'h07;
      trigger();
      run_report(8'hA5, 8'h5A, 8'h07, "snapshot", 1, 20);
      drop_done();
   endtask

   task automatic test_retrigger_and_held();
      accumulator = 16'hA55A;
      inst_count  = 8'h07;
      trigger();
      run_report(8'hA5, 8'h5A, 8'h07, "retrigger", 2, 50);
      check_quiet(40, "retrigger_no_extra");
      drop_done();
      accumulator = 16'h0001;
      inst_count  = 8'hFF;
      trigger();
      run_report(8'h00, 8'h01, 8'hFF, "second_report", 0, -1);
      check_quiet(500, "held_done");
      drop_done();
   endtask

   task automatic test_reset_mid();
      accumulator = 16'hA55A;
      inst_count  = 8'h07;
      trigger();
      run_report(8'hA5, 8'h5A, 8'h07, "reset_mid", 3, 57);
      check_quiet(5, "reset_mid_hold");
      @(negedge clk);
      rst = 1'b1;
      run_report(8'hA5, 8'h5A, 8'h07, "after_reset", 0, -1);
      drop_done();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_snapshot();
      test_retrigger_and_held();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/bip_uart_interface.md
Name: bip_uart_interface

Overview:
Reporting block that sits beside the BIP processor core. When the core signals program completion, the block snapshots the 16-bit accumulator and 8-bit instruction count. It then serialises them as three UART 8N1 frames on a single TX line. It sits at the top level between the BIP core and the board UART pin.

Parameters:
CLKS_PER_BIT, 5208, clock cycles per UART bit (50 MHz / 9600 baud); legal range 2..65535.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst  input  1  asynchronous, active-low reset.
accumulator  input  16  BIP accumulator value; sampled on a done edge.
inst_count  input  8  BIP executed-instruction count; sampled on a done edge.
bip_done  input  1  BIP completion flag, level signal, held high once the program halts.
o_tx  output  1  UART serial output, idle high.

Behaviour:
- Reset (rst=0, asynchronous):
  - o_tx=1; FSM=IDLE.
  - Edge-detect register cleared to 0.
  - Snapshot registers cleared to 0.
  - Bit and baud counters cleared to 0.
  - Reset mid-frame aborts immediately: o_tx=1 in the same instant, no partial frame resumes after release.
- Done detection:
  - A done edge is a clock edge where bip_done=1 and the registered previous sample=0.
  - bip_done already high at the first edge after reset release counts as an edge.
- Snapshot: on the done edge in IDLE, latch accumulator and inst_count, then enter SEND.
  - Input changes after the snapshot do not affect transmitted data.
- Byte order: byte0=accumulator[15:8], byte1=accumulator[7:0], byte2=inst_count.
- Frame format, per byte:
  - Start bit 0, then 8 data bits LSB first, then stop bit 1.
  - Every bit lasts exactly CLKS_PER_BIT cycles.
- Latency: o_tx goes low on the clock edge following the done-edge sample, i.e. 1 cycle after the done edge.
- Frames are back-to-back with no idle gap: the next start bit begins the cycle after the previous stop bit ends.
- Total transmission length: 30*CLKS_PER_BIT cycles. After the last stop bit, o_tx stays 1.
- FSM states:
  - IDLE: waits for a done edge.
  - START, DATA (bit index 0..7), STOP: per-byte frame states.
  - WAIT_LOW: entered after byte2's stop bit.
- FSM transitions:
  - STOP with byte index <2: go to START and increment the byte index.
  - WAIT_LOW: go to IDLE once bip_done=0, which re-arms the block.
  - If bip_done is already 0 when byte2 completes, go to IDLE directly.
- Done edges arriving during START/DATA/STOP/WAIT_LOW are ignored; no queuing, no restart.
  - The edge register still tracks bip_done every cycle.
- Exactly one report is sent per bip_done rising edge.
- o_tx is driven from a register (glitch-free).
- Counters:
  - Baud counter counts 0..CLKS_PER_BIT-1 and wraps on each bit boundary.
  - Bit index wraps 7→0 on the DATA→STOP transition.

Test Plan:
- Reset hold: rst=0 for 10 cycles with bip_done toggling -> o_tx=1 throughout, no frame after release while bip_done=0.
- Basic report: CLKS_PER_BIT=4, accumulator=16'hA55A, inst_count=8'h07, bip_done rises -> o_tx low 1 cycle later; decoded bytes 0xA5, 0x5A, 0x07 with stop bits=1; line high after 120 cycles.
- Snapshot isolation: same as basic report, but accumulator changes to 16'h1234 mid-frame -> transmitted bytes remain 0xA5, 0x5A, 0x07.
- Ignore retrigger: bip_done pulses low then high during byte1 -> exactly 3 bytes sent. Then drop bip_done, raise it with accumulator=16'h0001, inst_count=8'hFF -> second report 0x00, 0x01, 0xFF.
- Held done: bip_done stays high for 500 cycles after a report -> no second transmission.
- Reset mid-operation: assert rst during byte1 data bit 3 -> o_tx=1 immediately. After release with bip_done high, a fresh full 3-byte report is sent from byte0.
